alu_control_sequencer: RTL
==========================

Name: alu_control_sequencer

Overview:
Parametrised successor to the single-cycle ALU control decoder. Decodes {ALUOp, function} into an ALU operation code, registers the result for the EX stage, and adds a multi-cycle sequencer for MULT/MULTU/DIV/DIVU. While a multiply/divide is in progress it drives the iterative unit's step strobes and stalls the issue side. Sits between the main control unit / ID stage and the ALU plus HI/LO mult-div unit.

Parameters:
ALUOP_WIDTH, 3, width of alu_op from the main control unit
FUNCT_WIDTH, 6, width of the instruction function field
OPER_WIDTH, 4, width of alu_operation; codes are zero-extended when wider than 4; must be >= 4
MD_CYCLES, 32, iterations of a mult/div operation; must be >= 1
CNT_WIDTH, $clog2(MD_CYCLES+1), derived localparam for the step counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
flush  in  1  synchronous cancel of the captured or in-flight operation
issue_valid  in  1  alu_op/alu_function valid this cycle
issue_ready  out  1  sequencer accepts an issue this cycle
alu_op  in  ALUOP_WIDTH  operation class from the main control unit
alu_function  in  FUNCT_WIDTH  instruction function field
alu_operation  out  OPER_WIDTH  registered ALU operation code
op_valid  out  1  one-cycle strobe: alu_operation is fresh
illegal_op  out  1  one-cycle strobe alongside op_valid when the decode hit default
md_start  out  1  one-cycle pulse: mult/div unit loads its operands
md_step  out  1  mult/div unit performs one iteration this cycle
hilo_write  out  1  one-cycle pulse: commit the HI/LO result
stall  out  1  pipeline hold request

Behaviour:
- Decode table (combinational, casex on {alu_op, alu_function}):
  - R-type (alu_op=111): AND 100100->0000, OR 100101->0001, NOR 100111->0010, ADD 100000->0011, SUB 100010->0100, SLL 000000->0110, SRL 000010->0111, MULT 011000->1010, MULTU 011001->1011, DIV 011010->1100, DIVU 011011->1101, MFHI 010000->1110, MFLO 010010->1111.
  - I-type (function ignored): LUI 000->0101, BCH 001->0100, LW 010->0011, SW 011->0011, ADDI 100->0011, ORI 101->0001, ANDI 110->0000.
  - Anything else maps to INVALID = 1001.
- issue_ready = (state==IDLE). stall = (state!=IDLE). Both are combinational from state.
- FSM states are IDLE, MD_RUN and MD_DONE.
  - IDLE: an accepted issue (issue_valid & issue_ready & !flush) registers the decoded code. On the next edge op_valid is 1 and illegal_op is 1 if the code is INVALID. If the code is 1010..1101, the FSM goes to MD_RUN, md_start=1 on that same cycle, and the counter loads MD_CYCLES-1.
  - MD_RUN: md_step=1 every cycle. While counter != 0, it decrements. At counter==0 the FSM goes to MD_DONE. MD_RUN lasts exactly MD_CYCLES cycles.
  - MD_DONE: hilo_write=1 for one cycle, then the FSM returns to IDLE.
- Latency: issue at cycle 0 gives op_valid at cycle 1. For a mult/div issued at cycle 0, hilo_write is at cycle MD_CYCLES+1 and issue_ready returns at cycle MD_CYCLES+2.
- Back-to-back single-cycle issues are accepted every cycle, with op_valid high on consecutive cycles.
- alu_operation holds its last value when no new issue is accepted.
- flush:
  - In IDLE, flush beats issue_valid: nothing is captured and op_valid=0 next cycle.
  - In MD_RUN or MD_DONE, flush returns the FSM to IDLE on the next edge, clears the counter, and suppresses any further md_step and hilo_write.
- MFHI/MFLO are decoded as ordinary single-cycle operations. They cannot issue during a mult/div because issue_ready=0.
- Reset, asynchronous and active-high, at any time including mid-MD_RUN:
  - state=IDLE, counter=0
  - alu_operation=INVALID zero-extended
  - op_valid, illegal_op, md_start, md_step and hilo_write all 0
  - After release: issue_ready=1, stall=0.

Decomposition:
- Shared package alu_ctrl_pkg holds the ALU op codes (AND..MFLO, INVALID), the ALUOp class constants, the R-type function constants, and the FSM state enum.
- One natural sub-module: alu_op_decoder, the purely combinational decode table, reusable by the single-cycle datapath.
- The FSM and counter stay in alu_control_sequencer.

Test Plan:
- Reset asserted, then released with no issue -> alu_operation=1001, all strobes 0, issue_ready=1, stall=0.
- Issue every table entry on consecutive cycles, e.g. 111_100010 -> 0100 and 101_xxxxxx -> 0001 -> each code appears one cycle later with op_valid=1; illegal 111_111111 -> 1001 with illegal_op=1.
- MULT (111_011000) at cycle 0 with MD_CYCLES=32 -> md_start and op_valid at cycle 1; md_step high cycles 1..32; hilo_write at cycle 33; issue_ready=0 on cycles 1..33 and 1 at cycle 34; issue_valid held high meanwhile is ignored.
- MD_CYCLES=1 with DIVU -> md_step only at cycle 1, hilo_write at cycle 2, IDLE at cycle 3.
- flush at cycle 10 of a DIV -> md_step low from cycle 11, no hilo_write, issue_ready=1 at cycle 11; flush together with issue_valid in IDLE -> no op_valid.
- Reset asserted mid-MD_RUN (asynchronous, between edges) -> outputs clear immediately, no hilo_write after release, next ADD issue produces 0011 normally.

Source files
------------

// File: rtl/alu_control_sequencer_pkg.sv
// alu_ctrl_pkg: shared ALU op codes, ALUOp classes, R-type functions, FSM states and decode table
package alu_ctrl_pkg;
  localparam logic [3:0] OP_AND     = 4'b0000;
  localparam logic [3:0] OP_OR      = 4'b0001;
  localparam logic [3:0] OP_NOR     = 4'b0010;
  localparam logic [3:0] OP_ADD     = 4'b0011;
  localparam logic [3:0] OP_SUB     = 4'b0100;
  localparam logic [3:0] OP_LUI     = 4'b0101;
  localparam logic [3:0] OP_SLL     = 4'b0110;
  localparam logic [3:0] OP_SRL     = 4'b0111;
  localparam logic [3:0] OP_INVALID = 4'b1001;
  localparam logic [3:0] OP_MULT    = 4'b1010;
  localparam logic [3:0] OP_MULTU   = 4'b1011;
  localparam logic [3:0] OP_DIV     = 4'b1100;
  localparam logic [3:0] OP_DIVU    = 4'b1101;
  localparam logic [3:0] OP_MFHI    = 4'b1110;
  localparam logic [3:0] OP_MFLO    = 4'b1111;
  localparam logic [2:0] ALUOP_LUI  = 3'b000;
  localparam logic [2:0] ALUOP_BCH  = 3'b001;
  localparam logic [2:0] ALUOP_LW   = 3'b010;
  localparam logic [2:0] ALUOP_SW   = 3'b011;
  localparam logic [2:0] ALUOP_ADDI = 3'b100;
  localparam logic [2:0] ALUOP_ORI  = 3'b101;
  localparam logic [2:0] ALUOP_ANDI = 3'b110;
  localparam logic [2:0] ALUOP_R    = 3'b111;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_MD_RUN  = 2'd1;
  localparam logic [1:0] ST_MD_DONE = 2'd2;
  function automatic logic [3:0] decode_op(input logic [2:0] op, input logic [5:0] fn);
    logic [3:0] r;
    case (fn)
      FN_AND:   r = OP_AND;
      FN_OR:    r = OP_OR;
      FN_NOR:   r = OP_NOR;
      FN_ADD:   r = OP_ADD;
      FN_SUB:   r = OP_SUB;
      FN_SLL:   r = OP_SLL;
      FN_SRL:   r = OP_SRL;
      FN_MULT:  r = OP_MULT;
      FN_MULTU: r = OP_MULTU;
      FN_DIV:   r = OP_DIV;
      FN_DIVU:  r = OP_DIVU;
      FN_MFHI:  r = OP_MFHI;
      FN_MFLO:  r = OP_MFLO;
      default:  r = OP_INVALID;
    endcase
    case (op)
      ALUOP_R:    decode_op = r;
      ALUOP_LUI:  decode_op = OP_LUI;
      ALUOP_BCH:  decode_op = OP_SUB;
      ALUOP_LW:   decode_op = OP_ADD;
      ALUOP_SW:   decode_op = OP_ADD;
      ALUOP_ADDI: decode_op = OP_ADD;
      ALUOP_ORI:  decode_op = OP_OR;
      default:    decode_op = OP_AND;
    endcase
  endfunction
endpackage

// File: rtl/alu_control_sequencer_if.sv
// alu_control_sequencer_if: issue-side and mult/div control bundle of the ALU control sequencer
interface alu_control_sequencer_if #(
  parameter int ALUOP_WIDTH = 3,
  parameter int FUNCT_WIDTH = 6,
  parameter int OPER_WIDTH  = 4
);
  logic                   flush;
  logic                   issue_valid;
  logic                   issue_ready;
  logic [ALUOP_WIDTH-1:0] alu_op;
  logic [FUNCT_WIDTH-1:0] alu_function;
  logic [OPER_WIDTH-1:0]  alu_operation;
  logic                   op_valid;
  logic                   illegal_op;
  logic                   md_start;
  logic                   md_step;
  logic                   hilo_write;
  logic                   stall;
  modport master (
    output flush, issue_valid, alu_op, alu_function,
    input  issue_ready, alu_operation, op_valid, illegal_op, md_start, md_step, hilo_write, stall
  );
  modport slave (
    input  flush, issue_valid, alu_op, alu_function,
    output issue_ready, alu_operation, op_valid, illegal_op, md_start, md_step, hilo_write, stall
  );
endinterface

// File: rtl/alu_control_sequencer_decoder.sv
// alu_op_decoder: combinational {ALUOp, function} to ALU operation code table
module alu_op_decoder
  import alu_ctrl_pkg::*;
#(
  parameter int ALUOP_WIDTH = 3,
  parameter int FUNCT_WIDTH = 6,
  parameter int OPER_WIDTH  = 4
) (
  input  logic [ALUOP_WIDTH-1:0] alu_op_i,
  input  logic [FUNCT_WIDTH-1:0] alu_function_i,
  output logic [OPER_WIDTH-1:0]  alu_operation_o
);
  logic op_ok, fn_ok;
  assign op_ok = (alu_op_i >> 3) == '0;
  assign fn_ok = ((alu_function_i >> 6) == '0) || (alu_op_i[2:0] != ALUOP_R);
  assign alu_operation_o = OPER_WIDTH'(op_ok && fn_ok ? decode_op(alu_op_i[2:0], alu_function_i[5:0]) : OP_INVALID);
endmodule

// File: rtl/alu_control_sequencer.sv
// alu_control_sequencer: registered ALU op decode plus multi-cycle mult/div sequencer
module alu_control_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int ALUOP_WIDTH = 3,
  parameter int FUNCT_WIDTH = 6,
  parameter int OPER_WIDTH  = 4,
  parameter int MD_CYCLES   = 32
) (
  input logic                 clk,
  input logic                 reset,
  alu_control_sequencer_if.slave bus
);
  localparam int CNT_WIDTH = $clog2(MD_CYCLES + 1);
  logic [1:0]            state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [OPER_WIDTH-1:0] oper_q, dec;
  logic                  op_valid_q, illegal_q, md_start_q;
  logic                  accept, is_md;
  alu_op_decoder #(
    .ALUOP_WIDTH(ALUOP_WIDTH),
    .FUNCT_WIDTH(FUNCT_WIDTH),
    .OPER_WIDTH (OPER_WIDTH)
  ) u_dec (
    .alu_op_i       (bus.alu_op),
    .alu_function_i (bus.alu_function),
    .alu_operation_o(dec)
  );
  assign accept = bus.issue_valid && state_q == ST_IDLE && !bus.flush;
  assign is_md  = dec >= OPER_WIDTH'(OP_MULT) && dec <= OPER_WIDTH'(OP_DIVU);
  assign bus.issue_ready   = state_q == ST_IDLE;
  assign bus.stall         = state_q != ST_IDLE;
  assign bus.md_step       = state_q == ST_MD_RUN;
  assign bus.hilo_write    = state_q == ST_MD_DONE;
  assign bus.alu_operation = oper_q;
  assign bus.op_valid      = op_valid_q;
  assign bus.illegal_op    = illegal_q;
  assign bus.md_start      = md_start_q;
  // next state: launch on mult/div accept, count down iterations, flush aborts to IDLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_IDLE) begin
      if (accept && is_md) begin
        state_d = ST_MD_RUN;
        cnt_d   = CNT_WIDTH'(MD_CYCLES - 1);
      end
    end else if (bus.flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (state_q == ST_MD_RUN) begin
      state_d = cnt_q == '0 ? ST_MD_DONE : ST_MD_RUN;
      cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - CNT_WIDTH'(1);
    end else begin
      state_d = ST_IDLE;
    end
  end
  // state, counter and registered decode outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      oper_q     <= OPER_WIDTH'(OP_INVALID);
      op_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
      md_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      oper_q     <= accept ? dec : oper_q;
      op_valid_q <= accept;
      illegal_q  <= accept && dec == OPER_WIDTH'(OP_INVALID);
      md_start_q <= accept && is_md;
    end
  end
endmodule
